// File: rtl/sd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : sd_pkg                                                       |
// | Description : Shared definitions for the sphere-decoder metric path and    |
// |               the received-vector generator. Holds the fixed-point         |
// |               constants, the 8-PSK constellation table (as coefficient     |
// |               codes), the controller state encoding, the MAC schedule      |
// |               (column/row per step) and the noise LFSR step function.      |
// |               The noise LFSR is only used when RXGEN_NOISE_EN is defined.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package sd_pkg;

    // Default fixed-point format constants (Q18.14 at the default FRAC).
    localparam int SD_FRAC = 14;
    localparam int SD_ONE  = 1 << SD_FRAC;
    localparam int SD_C707 = 11585;   // round(0.70710678 * 2^14)

    localparam int          MAC_STEPS   = 10;
    localparam int          NOISE_STEPS = 8;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11.
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    // Controller states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_NOISE = 2'd2,
        ST_HOLD  = 2'd3
    } rxgen_state_e;

    // Each constellation component is one of five values; the width-dependent
    // numeric value is produced by the multiplier from its own FRAC.
    typedef enum logic [2:0] {
        COEF_ZERO    = 3'd0,
        COEF_POS_ONE = 3'd1,
        COEF_NEG_ONE = 3'd2,
        COEF_POS_C   = 3'd3,
        COEF_NEG_C   = 3'd4
    } psk_coef_e;

    // cos/sin(1/sqrt 2) scaled to any FRAC in 1..29, rounded to nearest.
    // 759250124 is 0.70710678 * 2^30.
    function automatic longint c707_for(input int frac);
        longint scaled;
        scaled = 64'sd759250124;
        return (scaled + (64'sd1 <<< (29 - frac))) >>> (30 - frac);
    endfunction

    // Point k sits at k*45 degrees.
    function automatic psk_coef_e psk_re_code(input logic [2:0] sym);
        case (sym)
            3'd0:    return COEF_POS_ONE;
            3'd1:    return COEF_POS_C;
            3'd2:    return COEF_ZERO;
            3'd3:    return COEF_NEG_C;
            3'd4:    return COEF_NEG_ONE;
            3'd5:    return COEF_NEG_C;
            3'd6:    return COEF_ZERO;
            default: return COEF_POS_C;
        endcase
    endfunction

    function automatic psk_coef_e psk_im_code(input logic [2:0] sym);
        case (sym)
            3'd0:    return COEF_ZERO;
            3'd1:    return COEF_POS_C;
            3'd2:    return COEF_POS_ONE;
            3'd3:    return COEF_POS_C;
            3'd4:    return COEF_ZERO;
            3'd5:    return COEF_NEG_C;
            3'd6:    return COEF_NEG_ONE;
            default: return COEF_NEG_C;
        endcase
    endfunction

    // MAC step i walks the upper triangle row by row:
    // R0..R3 -> row 0 cols 0..3, R4..R6 -> row 1 cols 1..3,
    // R7,R8 -> row 2 cols 2,3, R9 -> row 3 col 3.
    function automatic logic [1:0] mac_col(input logic [3:0] idx);
        case (idx)
            4'd0:    return 2'd0;
            4'd1:    return 2'd1;
            4'd2:    return 2'd2;
            4'd3:    return 2'd3;
            4'd4:    return 2'd1;
            4'd5:    return 2'd2;
            4'd6:    return 2'd3;
            4'd7:    return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] mac_row(input logic [3:0] idx);
        if (idx <= 4'd3) begin
            return 2'd0;
        end else if (idx <= 4'd6) begin
            return 2'd1;
        end else if (idx <= 4'd8) begin
            return 2'd2;
        end
        return 2'd3;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmplx_psk_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cmplx_psk_mult                                               |
// | Description : Combinational complex multiply of one R entry by an 8-PSK    |
// |               constellation point. Each component is formed at full        |
// |               2*WIDTH precision, arithmetically shifted right by FRAC and  |
// |               truncated to WIDTH bits.                                     |
// | Ports       : r_real/r_imag  in  WIDTH  signed R entry                     |
// |               sym            in  3      8-PSK symbol index                 |
// |               p_real/p_imag  out WIDTH  signed product                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module cmplx_psk_mult
    import sd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 14
) (
    input  logic signed [WIDTH-1:0] r_real,
    input  logic signed [WIDTH-1:0] r_imag,
    input  logic        [2:0]       sym,
    output logic signed [WIDTH-1:0] p_real,
    output logic signed [WIDTH-1:0] p_imag
);

    localparam logic signed [WIDTH-1:0] c_one  = WIDTH'(64'sd1 <<< FRAC);
    localparam logic signed [WIDTH-1:0] c_c707 = WIDTH'(c707_for(FRAC));

    function automatic logic signed [WIDTH-1:0] coef_val(input psk_coef_e code);
        case (code)
            COEF_POS_ONE: return c_one;
            COEF_NEG_ONE: return -c_one;
            COEF_POS_C:   return c_c707;
            COEF_NEG_C:   return -c_c707;
            default:      return '0;
        endcase
    endfunction

    logic signed [WIDTH-1:0]   w_c_re;
    logic signed [WIDTH-1:0]   w_c_im;
    logic signed [2*WIDTH-1:0] w_a;
    logic signed [2*WIDTH-1:0] w_b;
    logic signed [2*WIDTH-1:0] w_cr;
    logic signed [2*WIDTH-1:0] w_ci;
    logic signed [2*WIDTH-1:0] w_full_re;
    logic signed [2*WIDTH-1:0] w_full_im;

    assign w_c_re = coef_val(psk_re_code(sym));
    assign w_c_im = coef_val(psk_im_code(sym));

    assign w_a  = {{WIDTH{r_real[WIDTH-1]}}, r_real};
    assign w_b  = {{WIDTH{r_imag[WIDTH-1]}}, r_imag};
    assign w_cr = {{WIDTH{w_c_re[WIDTH-1]}}, w_c_re};
    assign w_ci = {{WIDTH{w_c_im[WIDTH-1]}}, w_c_im};

    // (a + jb)(c + jd) = (ac - bd) + j(ad + bc)
    assign w_full_re = (w_a * w_cr) - (w_b * w_ci);
    assign w_full_im = (w_a * w_ci) + (w_b * w_cr);

    assign p_real = WIDTH'(w_full_re >>> FRAC);
    assign p_imag = WIDTH'(w_full_im >>> FRAC);

endmodule
`default_nettype wire

// File: rtl/rx_vector_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rx_vector_gen                                                |
// | Description : Builds the noiseless received vector y = R*s for a 4x4       |
// |               upper-triangular complex R and four 8-PSK symbols, using one |
// |               shared complex multiplier over 10 MAC cycles. Results are    |
// |               held with a valid/ready handshake.                           |
// |               Optional feature macro RXGEN_NOISE_EN: adds an 8-cycle NOISE |
// |               phase injecting sign-extended LFSR bytes into y0r..y3i.      |
// | Ports       : clk, rst_n (async, active low)                               |
// |               in_valid/in_ready, S_0..S_3, R0..R9_real/imag  (input side)  |
// |               out_valid/out_ready, y0..y3_real/imag          (output side) |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rx_vector_gen
    import sd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic        [2:0]       S_0,
    input  logic        [2:0]       S_1,
    input  logic        [2:0]       S_2,
    input  logic        [2:0]       S_3,
    input  logic signed [WIDTH-1:0] R0_real,
    input  logic signed [WIDTH-1:0] R0_imag,
    input  logic signed [WIDTH-1:0] R1_real,
    input  logic signed [WIDTH-1:0] R1_imag,
    input  logic signed [WIDTH-1:0] R2_real,
    input  logic signed [WIDTH-1:0] R2_imag,
    input  logic signed [WIDTH-1:0] R3_real,
    input  logic signed [WIDTH-1:0] R3_imag,
    input  logic signed [WIDTH-1:0] R4_real,
    input  logic signed [WIDTH-1:0] R4_imag,
    input  logic signed [WIDTH-1:0] R5_real,
    input  logic signed [WIDTH-1:0] R5_imag,
    input  logic signed [WIDTH-1:0] R6_real,
    input  logic signed [WIDTH-1:0] R6_imag,
    input  logic signed [WIDTH-1:0] R7_real,
    input  logic signed [WIDTH-1:0] R7_imag,
    input  logic signed [WIDTH-1:0] R8_real,
    input  logic signed [WIDTH-1:0] R8_imag,
    input  logic signed [WIDTH-1:0] R9_real,
    input  logic signed [WIDTH-1:0] R9_imag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] y0_real,
    output logic signed [WIDTH-1:0] y0_imag,
    output logic signed [WIDTH-1:0] y1_real,
    output logic signed [WIDTH-1:0] y1_imag,
    output logic signed [WIDTH-1:0] y2_real,
    output logic signed [WIDTH-1:0] y2_imag,
    output logic signed [WIDTH-1:0] y3_real,
    output logic signed [WIDTH-1:0] y3_imag
);

    // Port bundles as arrays so the latch and the MAC mux can be indexed.
    logic signed [WIDTH-1:0] w_in_re [0:9];
    logic signed [WIDTH-1:0] w_in_im [0:9];
    logic        [2:0]       w_in_sym[0:3];

    assign w_in_re = '{R0_real, R1_real, R2_real, R3_real, R4_real,
                       R5_real, R6_real, R7_real, R8_real, R9_real};
    assign w_in_im = '{R0_imag, R1_imag, R2_imag, R3_imag, R4_imag,
                       R5_imag, R6_imag, R7_imag, R8_imag, R9_imag};
    assign w_in_sym = '{S_0, S_1, S_2, S_3};

    rxgen_state_e r_state;
    rxgen_state_e w_state_nxt;

    logic        [3:0]       r_idx;     // MAC step, reused as NOISE step
    logic        [2:0]       r_sym   [0:3];
    logic signed [WIDTH-1:0] r_mat_re[0:9];
    logic signed [WIDTH-1:0] r_mat_im[0:9];
    logic signed [WIDTH-1:0] r_acc_re[0:3];
    logic signed [WIDTH-1:0] r_acc_im[0:3];

    logic                    w_accept;
    logic                    w_mac_last;
    logic        [1:0]       w_row;
    logic        [1:0]       w_col;
    logic signed [WIDTH-1:0] w_p_re;
    logic signed [WIDTH-1:0] w_p_im;

    assign w_accept   = (r_state == ST_IDLE) && in_valid;
    assign w_mac_last = (r_idx == 4'(MAC_STEPS - 1));
    assign w_row      = mac_row(r_idx);
    assign w_col      = mac_col(r_idx);

    cmplx_psk_mult #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mult (
        .r_real (r_mat_re[r_idx]),
        .r_imag (r_mat_im[r_idx]),
        .sym    (r_sym[w_col]),
        .p_real (w_p_re),
        .p_imag (w_p_im)
    );

`ifdef RXGEN_NOISE_EN
    logic        [15:0]      r_lfsr;
    logic                    w_noise_last;
    logic        [1:0]       w_noise_row;
    logic signed [WIDTH-1:0] w_noise;

    assign w_noise_last = (r_idx == 4'(NOISE_STEPS - 1));
    // Step k targets y(k/2), real for even k, imaginary for odd k.
    assign w_noise_row  = r_idx[2:1];
    assign w_noise      = {{(WIDTH-8){r_lfsr[7]}}, r_lfsr[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (r_state == ST_NOISE) begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_MAC;
                end
            end
            ST_MAC: begin
                if (w_mac_last) begin
`ifdef RXGEN_NOISE_EN
                    w_state_nxt = ST_NOISE;
`else
                    w_state_nxt = ST_HOLD;
`endif
                end
            end
`ifdef RXGEN_NOISE_EN
            ST_NOISE: begin
                if (w_noise_last) begin
                    w_state_nxt = ST_HOLD;
                end
            end
`endif
            ST_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            for (int k = 0; k < 4; k++) begin
                r_sym[k]    <= '0;
                r_acc_re[k] <= '0;
                r_acc_im[k] <= '0;
            end
            for (int k = 0; k < 10; k++) begin
                r_mat_re[k] <= '0;
                r_mat_im[k] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_idx <= '0;
                        for (int k = 0; k < 4; k++) begin
                            r_sym[k]    <= w_in_sym[k];
                            r_acc_re[k] <= '0;
                            r_acc_im[k] <= '0;
                        end
                        for (int k = 0; k < 10; k++) begin
                            r_mat_re[k] <= w_in_re[k];
                            r_mat_im[k] <= w_in_im[k];
                        end
                    end
                end
                ST_MAC: begin
                    // Modular accumulation: wrap-around is intended.
                    r_acc_re[w_row] <= r_acc_re[w_row] + w_p_re;
                    r_acc_im[w_row] <= r_acc_im[w_row] + w_p_im;
                    r_idx           <= w_mac_last ? 4'd0 : r_idx + 4'd1;
                end
`ifdef RXGEN_NOISE_EN
                ST_NOISE: begin
                    if (r_idx[0]) begin
                        r_acc_im[w_noise_row] <= r_acc_im[w_noise_row] + w_noise;
                    end else begin
                        r_acc_re[w_noise_row] <= r_acc_re[w_noise_row] + w_noise;
                    end
                    r_idx <= r_idx + 4'd1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_HOLD);

    assign y0_real = r_acc_re[0];
    assign y0_imag = r_acc_im[0];
    assign y1_real = r_acc_re[1];
    assign y1_imag = r_acc_im[1];
    assign y2_real = r_acc_re[2];
    assign y2_imag = r_acc_im[2];
    assign y3_real = r_acc_re[3];
    assign y3_imag = r_acc_im[3];

endmodule
`default_nettype wire

// File: tb/tb_rx_vector_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rx_vector_gen                                             |
// | Description : Self-checking bench for rx_vector_gen (WIDTH=32, FRAC=14).   |
// |               Directed vectors; expected y computed by a matrix-level      |
// |               model (plus LFSR noise model when RXGEN_NOISE_EN), with a    |
// |               few hand-computed literal results.                           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_rx_vector_gen;

`ifdef RXGEN_NOISE_EN
    localparam int c_lat = 18;   // edges from accept edge to first out_valid
`else
    localparam int c_lat = 10;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready;
    logic out_valid;
    logic        [2:0]  s_in[4];
    logic signed [31:0] rre[10];
    logic signed [31:0] rim[10];
    logic signed [31:0] yre[4];
    logic signed [31:0] yim[4];

    int checks = 0;
    int errors = 0;

    // Model state
    logic signed [31:0] exp_re[4];
    logic signed [31:0] exp_im[4];
    logic signed [31:0] got_re[4];
    logic signed [31:0] got_im[4];
    bit                 exp_armed = 1'b0;
    logic        [15:0] m_lfsr = 16'hACE1;

    int tbl_re[8] = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};
    int tbl_im[8] = '{0, 11585, 16384, 11585, 0, -11585, -16384, -11585};

    rx_vector_gen #(.WIDTH(32), .FRAC(14)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .S_0(s_in[0]), .S_1(s_in[1]), .S_2(s_in[2]), .S_3(s_in[3]),
        .R0_real(rre[0]), .R0_imag(rim[0]), .R1_real(rre[1]), .R1_imag(rim[1]),
        .R2_real(rre[2]), .R2_imag(rim[2]), .R3_real(rre[3]), .R3_imag(rim[3]),
        .R4_real(rre[4]), .R4_imag(rim[4]), .R5_real(rre[5]), .R5_imag(rim[5]),
        .R6_real(rre[6]), .R6_imag(rim[6]), .R7_real(rre[7]), .R7_imag(rim[7]),
        .R8_real(rre[8]), .R8_imag(rim[8]), .R9_real(rre[9]), .R9_imag(rim[9]),
        .out_valid(out_valid), .out_ready(out_ready),
        .y0_real(yre[0]), .y0_imag(yim[0]), .y1_real(yre[1]), .y1_imag(yim[1]),
        .y2_real(yre[2]), .y2_imag(yim[2]), .y3_real(yre[3]), .y3_imag(yim[3])
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // y_r = sum_{c>=r} R[r][c] * point(s_c); products floored to FRAC, sums mod 2^32.
    task automatic model_expected();
        int     base[4] = '{0, 4, 7, 9};
        int     e;
        longint pr_re;
        longint pr_im;
        for (int r = 0; r < 4; r++) begin
            exp_re[r] = 0;
            exp_im[r] = 0;
            for (int c = r; c < 4; c++) begin
                e = base[r] + (c - r);
                pr_re = (longint'(rre[e]) * tbl_re[s_in[c]] - longint'(rim[e]) * tbl_im[s_in[c]]) >>> 14;
                pr_im = (longint'(rre[e]) * tbl_im[s_in[c]] + longint'(rim[e]) * tbl_re[s_in[c]]) >>> 14;
                exp_re[r] = exp_re[r] + 32'(pr_re);
                exp_im[r] = exp_im[r] + 32'(pr_im);
            end
        end
`ifdef RXGEN_NOISE_EN
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) exp_re[k/2] = exp_re[k/2] + 32'(longint'($signed(m_lfsr[7:0])));
            else            exp_im[k/2] = exp_im[k/2] + 32'(longint'($signed(m_lfsr[7:0])));
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
`endif
    endtask

    // Compare process: whenever y is presented, it must equal the model.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            check("valid_expected", exp_armed, 1);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("y%0d_real", k), yre[k], exp_re[k]);
                check($sformatf("y%0d_imag", k), yim[k], exp_im[k]);
            end
            check("in_ready_busy", in_ready, 0);
        end
    end

    task automatic clear_vec();
        for (int k = 0; k < 10; k++) begin
            rre[k] = 0;
            rim[k] = 0;
        end
        for (int k = 0; k < 4; k++) s_in[k] = 3'd0;
    endtask

    task automatic scramble_inputs();
        for (int k = 0; k < 10; k++) begin
            rre[k] = $urandom;
            rim[k] = $urandom;
        end
        for (int k = 0; k < 4; k++) s_in[k] = 3'($urandom_range(7, 0));
    endtask

    // Called at a falling edge with the DUT idle. hold = cycles out_ready stays low.
    task automatic run_vector(input int hold);
        int  lat;
        bit  seen;
        check("in_ready_idle", in_ready, 1);
        model_expected();
        exp_armed = 1'b1;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble_inputs();   // latched copy must be used
        check("in_ready_after_accept", in_ready, 0);
        seen = 1'b0;
        lat  = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat  = k;
                seen = 1'b1;
                break;
            end
        end
        check("latency", lat, c_lat);
        for (int k = 0; k < 4; k++) begin
            got_re[k] = yre[k];
            got_im[k] = yim[k];
        end
        if (seen && hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                in_valid = ~in_valid;
                @(posedge clk);
                #1;
                check("hold_out_valid", out_valid, 1);
                check("hold_in_ready", in_ready, 0);
            end
            in_valid  = 1'b1;   // present at the completion edge: must not be taken
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("valid_dropped", out_valid, 0);
        check("in_ready_rises", in_ready, 1);
        @(posedge clk);
        #1;
        check("no_same_cycle_accept", in_ready, 1);
        exp_armed = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_diag_vec();
        clear_vec();
        rre[0] = 16384; rre[4] = 16384; rre[7] = 16384; rre[9] = 16384;
    endtask

    task automatic check_diag_literal(input string tag);
`ifdef RXGEN_NOISE_EN
        // LFSR bytes from seed ACE1: E1,70,38,9C,4E,27,13,89
        check({tag, "_y0r"}, got_re[0], 16353); check({tag, "_y0i"}, got_im[0], 112);
        check({tag, "_y1r"}, got_re[1], 16440); check({tag, "_y1i"}, got_im[1], -100);
        check({tag, "_y2r"}, got_re[2], 16462); check({tag, "_y2i"}, got_im[2], 39);
        check({tag, "_y3r"}, got_re[3], 16403); check({tag, "_y3i"}, got_im[3], -119);
`else
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_y%0dr", tag, k), got_re[k], 16384);
            check($sformatf("%s_y%0di", tag, k), got_im[k], 0);
        end
`endif
    endtask

    initial begin
        clear_vec();
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("rst_y_real", yre[k], 0);
            check("rst_y_imag", yim[k], 0);
        end
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n  = 1'b1;
        m_lfsr = 16'hACE1;
        repeat (3) begin
            @(negedge clk);
            check("idle_out_valid", out_valid, 0);
            check("idle_in_ready", in_ready, 1);
        end

        // Diagonal identity, all symbols 0
        set_diag_vec();
        run_vector(0);
        check_diag_literal("t2");

`ifndef RXGEN_NOISE_EN
        // Last column only, S_3 = 2 -> every row (0, 1.0)
        clear_vec();
        rre[3] = 16384; rre[6] = 16384; rre[8] = 16384; rre[9] = 16384;
        s_in[3] = 3'd2;
        run_vector(0);
        for (int k = 0; k < 4; k++) begin
            check("t3_real", got_re[k], 0);
            check("t3_imag", got_im[k], 16384);
        end

        // Diagonal 45-degree point
        clear_vec();
        rre[9] = 16384; s_in[3] = 3'd1;
        run_vector(0);
        check("t4a_y3r", got_re[3], 11585);
        check("t4a_y3i", got_im[3], 11585);
        check("t4a_y0r", got_re[0], 0);

        // (-1 + j) * (-1) = (1 - j)
        clear_vec();
        rre[9] = -16384; rim[9] = 16384; s_in[3] = 3'd4;
        run_vector(0);
        check("t4b_y3r", got_re[3], 16384);
        check("t4b_y3i", got_im[3], -16384);
`endif

        // Dense vector with wrap-around and negative flooring
        rre = '{32'sh7FFF0000, 32'sh40000000, -12345, 98765, 54321, -3, 1, 777777, -888888, 16383};
        rim = '{-1, 17, 2222, -33333, 4444, 5, -7, 0, 31, -16385};
        s_in = '{3'd0, 3'd0, 3'd5, 3'd7};
        run_vector(0);

        // Back-pressure: out_ready low 6 cycles while in_valid toggles
        rre = '{1000, -2000, 3000, -4000, 5000, -6000, 7000, -8000, 9000, -10000};
        rim = '{-11, 22, -33, 44, -55, 66, -77, 88, -99, 110};
        s_in = '{3'd3, 3'd6, 3'd1, 3'd4};
        run_vector(6);
        // Next vector accepted after the held one
        clear_vec();
        rre[9] = 16384; s_in[3] = 3'd1;
        run_vector(0);

        // Reset during MAC step 5
        rre = '{5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
        rim = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        s_in = '{3'd2, 3'd2, 3'd2, 3'd2};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("midrst_y_real", yre[k], 0);
            check("midrst_y_imag", yim[k], 0);
        end
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        m_lfsr = 16'hACE1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_diag_vec();
        run_vector(0);
        check_diag_literal("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
